// File: rtl/ins_fetch_buf_if.sv
// ins_fetch_buf_if
//   Bundles the decode-side handshake and the instruction BRAM port B bus of
//   the fetch buffer. Signal names match the original flat port list.
//   master : the fetch buffer (drives instr_*_o and the ins_mem_* request side)
//   slave  : the environment (core redirect/decode ready and the BRAM)
//   Parameter: ADDR_W - byte-address width of PCs and the BRAM address.
interface ins_fetch_buf_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              instr_valid_o;
  logic              instr_ready_i;
  logic [31:0]       instr_o;
  logic [ADDR_W-1:0] instr_pc_o;
  logic              ins_mem_clkb;
  logic              ins_mem_enb;
  logic              ins_mem_rstb;
  logic [3:0]        ins_mem_web;
  logic [ADDR_W-1:0] ins_mem_addrb;
  logic [31:0]       ins_mem_dinb;
  logic              ins_mem_rstb_busy;
  logic [31:0]       ins_mem_doutb;

  modport master (
    input  redirect_i, redirect_pc_i, instr_ready_i,
    input  ins_mem_rstb_busy, ins_mem_doutb,
    output instr_valid_o, instr_o, instr_pc_o,
    output ins_mem_clkb, ins_mem_enb, ins_mem_rstb, ins_mem_web,
    output ins_mem_addrb, ins_mem_dinb
  );

  modport slave (
    output redirect_i, redirect_pc_i, instr_ready_i,
    output ins_mem_rstb_busy, ins_mem_doutb,
    input  instr_valid_o, instr_o, instr_pc_o,
    input  ins_mem_clkb, ins_mem_enb, ins_mem_rstb, ins_mem_web,
    input  ins_mem_addrb, ins_mem_dinb
  );
endinterface

// File: rtl/ins_fetch_buf.sv
// ins_fetch_buf
//   Instruction-fetch front end between the PC logic and instruction BRAM
//   port B. Issues sequential word reads, tracks reads in flight across the
//   BRAM latency (BRAM_LAT = 1 or 2), queues returned words in a FIFO and
//   presents {pc, instruction} to decode over valid/ready. A redirect flushes
//   queued entries and invalidates in-flight reads through a 1-bit epoch.
//
// Ports
//   clk, reset_n         core clock, asynchronous active-low reset
//   bus (master)         redirect_i/redirect_pc_i, instr_valid_o/instr_ready_i,
//                        instr_o/instr_pc_o, ins_mem_* BRAM port B
//   perf_fetch_o [31:0]  accepted pops      (only with FETCH_PERF_EN)
//   perf_flush_o [31:0]  redirect_i cycles  (only with FETCH_PERF_EN)
//
// Configuration macro: FETCH_PERF_EN adds the two performance counters.
module ins_fetch_buf #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       BRAM_LAT   = 1,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [31:0]       NOP_INSTR  = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  ins_fetch_buf_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_flush_o
`endif
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned CRD_W  = CNT_W + 1;
  localparam int unsigned ENT_W  = ADDR_W + 32;
  localparam int unsigned PIPE_W = BRAM_LAT * ADDR_W;

  // State
  logic [ADDR_W-1:0]               fetch_pc_q, fetch_pc_d;
  logic                            epoch_q, epoch_d;
  logic [BRAM_LAT-1:0]             pipe_vld_q, pipe_vld_d;
  logic [BRAM_LAT-1:0]             pipe_epoch_q, pipe_epoch_d;
  logic [BRAM_LAT-1:0][ADDR_W-1:0] pipe_pc_q, pipe_pc_d;
  logic [ENT_W-1:0]                fifo_q [FIFO_DEPTH];
  logic [ENT_W-1:0]                fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                count_q, count_d;

  // Control
  logic [CNT_W-1:0]  in_flight;
  logic [CRD_W-1:0]  credit_used;
  logic              issue;
  logic              push;
  logic              pop;
  logic              head_valid;
  logic              ret_vld;
  logic              ret_epoch;
  logic [ADDR_W-1:0] ret_pc;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ENT_W-1:0]  head;

  always_comb begin
    // Every valid pipe stage owns a FIFO slot, stale ones included, so a
    // read is only issued when its data is guaranteed somewhere to land.
    in_flight   = CNT_W'($countones(pipe_vld_q));
    credit_used = CRD_W'(count_q) + CRD_W'(in_flight);
    issue       = reset_n && !bus.redirect_i && !bus.ins_mem_rstb_busy &&
                  (credit_used < CRD_W'(FIFO_DEPTH));

    ret_vld     = pipe_vld_q[BRAM_LAT-1];
    ret_epoch   = pipe_epoch_q[BRAM_LAT-1];
    ret_pc      = pipe_pc_q[BRAM_LAT-1];

    // A redirect empties the FIFO, so neither a return nor a pop applies
    // in that cycle.
    push        = ret_vld && (ret_epoch == epoch_q) && !bus.redirect_i;
    head_valid  = (count_q != '0);
    pop         = head_valid && bus.instr_ready_i && !bus.redirect_i;
    head        = fifo_q[rd_ptr_q];
    redirect_pc = bus.redirect_pc_i & ~ADDR_W'(3);
  end

  // Next-state
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    epoch_d      = epoch_q ^ bus.redirect_i;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    // Stage 0 captures the issued read; each cycle the pipe shifts by one.
    pipe_vld_d   = (pipe_vld_q << 1) | BRAM_LAT'(issue);
    pipe_epoch_d = (pipe_epoch_q << 1) | BRAM_LAT'(epoch_q);
    pipe_pc_d    = (pipe_pc_q << ADDR_W) | PIPE_W'(fetch_pc_q);

    if (bus.redirect_i) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (push) begin
        fifo_d[wr_ptr_q] = {ret_pc, bus.ins_mem_doutb};
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q   <= RESET_PC;
      epoch_q      <= 1'b0;
      pipe_vld_q   <= '0;
      pipe_epoch_q <= '0;
      pipe_pc_q    <= '0;
      fifo_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      epoch_q      <= epoch_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_epoch_q <= pipe_epoch_d;
      pipe_pc_q    <= pipe_pc_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Outputs
  assign bus.instr_valid_o = head_valid;
  assign bus.instr_o       = head_valid ? head[31:0] : NOP_INSTR;
  assign bus.instr_pc_o    = head_valid ? head[ENT_W-1:32] : '0;
  assign bus.ins_mem_clkb  = clk;
  assign bus.ins_mem_enb   = issue;
  assign bus.ins_mem_rstb  = 1'b0;
  assign bus.ins_mem_web   = '0;
  assign bus.ins_mem_addrb = fetch_pc_q;
  assign bus.ins_mem_dinb  = '0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + 32'(pop);
    perf_flush_d = perf_flush_q + 32'(bus.redirect_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_ins_fetch_buf.sv
// Bench for ins_fetch_buf: BRAM model with word[i] = i, stream-level model
// of the expected issue address and head-of-queue PC.
module tb_ins_fetch_buf;

  localparam int unsigned LAT    = 2;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk;
  logic reset_n;

  ins_fetch_buf_if #(.ADDR_W(32)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;
`endif

  ins_fetch_buf #(
    .ADDR_W    (32),
    .BRAM_LAT  (LAT),
    .FIFO_DEPTH(DEPTH),
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.master)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_o(perf_fetch),
    .perf_flush_o(perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  // BRAM port B: registered read, optional output register for LAT=2
  logic [31:0] bram_q1, bram_q2;
  always_ff @(posedge clk) begin
    if (bus.ins_mem_enb) bram_q1 <= word_of(bus.ins_mem_addrb);
    bram_q2 <= bram_q1;
  end
  assign bus.ins_mem_doutb = (LAT == 1) ? bram_q1 : bram_q2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] exp_fetch_pc;
  logic [31:0] exp_head_pc;
  int          outstanding;
  int unsigned pop_cnt;
  int unsigned flush_cnt;
  bit          after_redirect;
  int unsigned idle_run;

  // Values sampled in the most recent cycle
  logic        last_valid, last_enb;
  logic [31:0] last_pc, last_addr;

  task automatic model_reset();
    exp_fetch_pc   = RST_PC;
    exp_head_pc    = RST_PC;
    outstanding    = 0;
    pop_cnt        = 0;
    flush_cnt      = 0;
    after_redirect = 1'b0;
    idle_run       = 0;
  endtask

  task automatic drive(input bit rdy, input bit busy, input bit redir, input logic [31:0] rpc);
    bus.instr_ready_i     = rdy;
    bus.ins_mem_rstb_busy = busy;
    bus.redirect_i        = redir;
    bus.redirect_pc_i     = rpc;
  endtask

  // Called at edge+1 with inputs already driven; samples at edge+2,
  // checks, advances the model, returns at the next edge+1.
  task automatic step();
    logic        v, en;
    logic [31:0] ins, pc, addr;
    #1;
    v    = bus.instr_valid_o;
    ins  = bus.instr_o;
    pc   = bus.instr_pc_o;
    en   = bus.ins_mem_enb;
    addr = bus.ins_mem_addrb;
    last_valid = v;
    last_pc    = pc;
    last_enb   = en;
    last_addr  = addr;

    if (after_redirect) chk("valid_after_redirect", 64'(v), 64'd0);
    if (!v) begin
      chk("nop_when_idle", 64'(ins), 64'(NOP));
    end else begin
      chk("head_pc", 64'(pc), 64'(exp_head_pc));
      chk("head_instr", 64'(ins), 64'(word_of(exp_head_pc)));
    end
    if (bus.redirect_i || bus.ins_mem_rstb_busy) chk("enb_blocked", 64'(en), 64'd0);
    if (en) begin
      chk("issue_addr", 64'(addr), 64'(exp_fetch_pc));
      outstanding++;
      chk("credit_bound", 64'(outstanding > int'(DEPTH)), 64'd0);
    end

    if (v || bus.redirect_i || bus.ins_mem_rstb_busy) idle_run = 0;
    else idle_run++;
    if (idle_run == 12) begin
      chk("liveness", 64'(v), 64'd1);
      idle_run = 0;
    end

    if (bus.redirect_i) begin
      exp_fetch_pc   = {bus.redirect_pc_i[31:2], 2'b00};
      exp_head_pc    = {bus.redirect_pc_i[31:2], 2'b00};
      outstanding    = 0;
      flush_cnt++;
      after_redirect = 1'b1;
    end else begin
      after_redirect = 1'b0;
      if (en) exp_fetch_pc = exp_fetch_pc + 32'd4;
      if (v && bus.instr_ready_i) begin
        exp_head_pc = exp_head_pc + 32'd4;
        outstanding--;
        pop_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_v;
    int unsigned cnt;
    bit seen;

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    model_reset();
    #3;
    chk("rst_valid", 64'(bus.instr_valid_o), 64'd0);
    chk("rst_instr", 64'(bus.instr_o), 64'(NOP));
    chk("rst_pc", 64'(bus.instr_pc_o), 64'd0);
    chk("rst_enb", 64'(bus.ins_mem_enb), 64'd0);
    chk("tie_rstb", 64'(bus.ins_mem_rstb), 64'd0);
    chk("tie_web", 64'(bus.ins_mem_web), 64'd0);
    chk("tie_dinb", 64'(bus.ins_mem_dinb), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Hold decode off for 10 cycles: exactly DEPTH issues, head stays at RESET_PC
    first_v = -1;
    cnt     = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) chk("first_issue_enb", 64'(last_enb), 64'd1);
      if (last_enb) cnt++;
      if (last_valid && first_v < 0) first_v = k;
      if (k == 2) chk("clkb_follows_clk", 64'(bus.ins_mem_clkb), 64'(clk));
    end
    chk("first_valid_cycle", 64'(first_v), 64'(LAT + 1));
    chk("hold_issue_cnt", 64'(cnt), 64'(DEPTH));
    chk("hold_enb_off", 64'(last_enb), 64'd0);
    chk("hold_head_pc", 64'(last_pc), 64'(RST_PC));

    // Streaming with ready held: one instruction per cycle in steady state
    drive(1'b1, 1'b0, 1'b0, '0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k >= 5 && last_valid) cnt++;
    end
    chk("throughput", 64'(cnt), 64'd15);

    // Busy for 3 cycles mid-stream
    drive(1'b1, 1'b1, 1'b0, '0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (last_enb) cnt++;
    end
    chk("busy_no_enb", 64'(cnt), 64'd0);
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 8; k++) step();

    // Redirect to an unaligned target while the queue is full
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 8; k++) step();
    chk("redir_full_valid", 64'(last_valid), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    step();
    drive(1'b1, 1'b0, 1'b0, '0);
    step();
    chk("redir_valid_low", 64'(last_valid), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (last_valid) begin
        seen = 1'b1;
        chk("redir_new_pc", 64'(last_pc), 64'h100);
      end
    end
    chk("redir_wait", 64'(seen), 64'd1);

    // Back-to-back redirects: the last one wins
    drive(1'b1, 1'b0, 1'b1, 32'h0000_2000);
    step();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_3000);
    step();
    drive(1'b1, 1'b0, 1'b0, '0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (last_valid) begin
        seen = 1'b1;
        chk("b2b_redir_pc", 64'(last_pc), 64'h3000);
      end
    end
    chk("b2b_redir_wait", 64'(seen), 64'd1);

    // Fetch address wrap at the top of the address space
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    step();
    drive(1'b1, 1'b0, 1'b0, '0);
    step();
    chk("wrap_first_addr", 64'(last_addr), 64'hFFFF_FFFC);
    step();
    chk("wrap_next_enb", 64'(last_enb), 64'd1);
    chk("wrap_next_addr", 64'(last_addr), 64'h0);
    for (int k = 0; k < 10; k++) step();

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 39) == 0), $urandom());
      step();
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetch_rand", 64'(perf_fetch), 64'(pop_cnt));
    chk("perf_flush_rand", 64'(perf_flush), 64'(flush_cnt));
`endif

    // Asynchronous reset mid-stream with reads in flight
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 6; k++) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.instr_valid_o), 64'd0);
    chk("mid_rst_instr", 64'(bus.instr_o), 64'(NOP));
    chk("mid_rst_pc", 64'(bus.instr_pc_o), 64'd0);
    chk("mid_rst_enb", 64'(bus.ins_mem_enb), 64'd0);
`ifdef FETCH_PERF_EN
    chk("mid_rst_perf_fetch", 64'(perf_fetch), 64'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, '0);
    step();
    chk("restart_enb", 64'(last_enb), 64'd1);
    chk("restart_addr", 64'(last_addr), 64'(RST_PC));

    // Two redirects then exactly five pops
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    step();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0080);
    step();
    for (int k = 0; k < 30 && pop_cnt < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("pop5_reached", 64'(pop_cnt == 5), 64'd1);
    step();
    step();
`ifdef FETCH_PERF_EN
    chk("perf_fetch_5", 64'(perf_fetch), 64'd5);
    chk("perf_flush_2", 64'(perf_flush), 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
